// File: rtl/fft_frame_sink_pkg.sv
// rtl/fft_frame_sink_pkg.sv - shared sizes, write-FSM encoding and float constants for fft_frame_sink
package fft_frame_sink_pkg;
  localparam int LEN_DEFAULT = 8192;
  localparam int AW_DEFAULT  = 13;
  localparam int DW_DEFAULT  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } wr_state_t;

  localparam logic [31:0] FLOAT_ONE = 32'h3F800000;
endpackage

// File: rtl/fft_frame_ram.sv
// rtl/fft_frame_ram.sv - two-bank simple dual-port sample RAM, address {bank,index}, registered read
module fft_frame_ram #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW:0]     wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW:0]     rd_addr,
  output logic [2*DW-1:0] rd_data
);
  logic [2*DW-1:0] mem [0:(2<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is cleared so the array itself still maps onto block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fft_frame_sink.sv
// rtl/fft_frame_sink.sv - Avalon-ST float I/Q frame sink with framing checks and ping-pong frame buffer
module fft_frame_sink
  import fft_frame_sink_pkg::*;
#(
  parameter int LEN = LEN_DEFAULT,
  parameter int AW  = AW_DEFAULT,
  parameter int DW  = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sink_valid,
  input  logic          sink_sop,
  input  logic          sink_eop,
  input  logic [DW-1:0] sink_real,
  input  logic [DW-1:0] sink_imag,
  output logic          sink_ready,
  output logic          frame_ready,
  input  logic          frame_ack,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_real,
  output logic [DW-1:0] rd_imag,
  output logic          rd_valid,
  input  logic          err_clr,
  output logic          err_short,
  output logic          err_long,
  output logic          err_sop,
  output logic [15:0]   frame_cnt
);
  wr_state_t       state, state_n;
  logic [AW-1:0]   idx, idx_n, widx;
  logic            wr_bank, rd_bank, wr_bank_n;
  logic [1:0]      full, full_n;
  logic            acc, last, we, complete, ack_hit;
  logic            ev_short, ev_long, ev_sop;
  logic [2*DW-1:0] rd_data;

  assign acc         = sink_valid & sink_ready;
  assign last        = (idx == AW'(LEN - 1));
  assign frame_ready = full[rd_bank];
  assign ack_hit     = frame_ack & full[rd_bank];
  assign wr_bank_n   = wr_bank ^ complete;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (acc) begin
      if (sink_sop) begin
        state_n = sink_eop ? ST_IDLE : ST_FILL;
      end else begin
        case (state)
          ST_FILL: begin
            if (sink_eop)  state_n = ST_IDLE;
            else if (last) state_n = ST_DROP;
          end
          ST_DROP: if (sink_eop) state_n = ST_IDLE;
          default: state_n = state;
        endcase
      end
    end
  end

  // A sop always restarts capture at index 0, whatever state it lands in.
  always_comb begin
    we       = 1'b0;
    widx     = idx;
    idx_n    = idx;
    ev_short = 1'b0;
    ev_long  = 1'b0;
    ev_sop   = 1'b0;
    complete = 1'b0;
    if (acc) begin
      if (sink_sop) begin
        ev_sop   = (state != ST_IDLE);
        ev_short = sink_eop;
        we       = ~sink_eop;
        widx     = '0;
        idx_n    = sink_eop ? '0 : AW'(1);
      end else if (state == ST_FILL) begin
        we = 1'b1;
        if (sink_eop) begin
          complete = last;
          ev_short = ~last;
          idx_n    = '0;
        end else if (last) begin
          ev_long = 1'b1;
          idx_n   = '0;
        end else begin
          idx_n = idx + AW'(1);
        end
      end
    end
  end

  always_comb begin
    full_n = full;
    if (ack_hit)  full_n[rd_bank] = 1'b0;
    if (complete) full_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      sink_ready <= 1'b0;
      frame_cnt  <= 16'd0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_sop    <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      idx     <= idx_n;
      full    <= full_n;
      wr_bank <= wr_bank_n;
      if (complete) frame_cnt <= frame_cnt + 16'd1;
      if (ack_hit)  rd_bank <= ~rd_bank;
      // Ready only moves at frame boundaries so a frame in flight is never throttled.
      if (state_n == ST_IDLE) sink_ready <= ~full_n[wr_bank_n];
      err_short <= (err_short & ~err_clr) | ev_short;
      err_long  <= (err_long  & ~err_clr) | ev_long;
      err_sop   <= (err_sop   & ~err_clr) | ev_sop;
      rd_valid  <= rd_en;
    end
  end

  fft_frame_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (we),
    .wr_addr ({wr_bank, widx}),
    .wr_data ({sink_real, sink_imag}),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (rd_data)
  );

  assign rd_real = rd_data[2*DW-1:DW];
  assign rd_imag = rd_data[DW-1:0];
endmodule

// File: tb/tb_fft_frame_sink.sv
// tb/tb_fft_frame_sink.sv - self-checking bench for fft_frame_sink with a frame-level reference model
module tb_fft_frame_sink;
  import fft_frame_sink_pkg::*;
  localparam int LEN = 16;
  localparam int AW  = 4;
  localparam int DW  = 32;

  logic          clk = 1'b0, reset = 1'b1;
  logic          sink_valid = 0, sink_sop = 0, sink_eop = 0;
  logic [DW-1:0] sink_real = '0, sink_imag = '0;
  logic          sink_ready, frame_ready, frame_ack = 0, rd_en = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_real, rd_imag;
  logic          rd_valid, err_clr = 0, err_short, err_long, err_sop;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  fft_frame_sink #(.LEN(LEN), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_ready(sink_ready), .frame_ready(frame_ready),
    .frame_ack(frame_ack), .rd_en(rd_en), .rd_addr(rd_addr), .rd_real(rd_real), .rd_imag(rd_imag),
    .rd_valid(rd_valid), .err_clr(err_clr), .err_short(err_short), .err_long(err_long),
    .err_sop(err_sop), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0, n_bad = 0, seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] i2f(input int n);
    logic [31:0] m;
    int p;
    m = (n < 0) ? -n : n;
    if (m == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 31; b++) if (m[b]) p = b;
    m = (m << (23 - p));
    return {(n < 0), 8'(127 + p), m[22:0]};
  endfunction

  // Model: assemble accepted beats into frames, keep up to two completed frames in arrival order.
  int          m_mode, m_n, m_head, m_cnt;
  logic [63:0] m_cur [LEN];
  logic [63:0] m_fr [2][LEN];
  bit          m_ready, m_es, m_el, m_ep, m_rdv, m_rdk;
  logic [15:0] m_fcnt;
  logic [63:0] m_rdd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_n = 0; m_head = 0; m_cnt = 0; m_ready = 0;
      m_es = 0; m_el = 0; m_ep = 0; m_rdv = 0; m_rdk = 0; m_fcnt = 0;
    end else begin
      bit es, el, ep;
      logic [63:0] d;
      es = 0; el = 0; ep = 0;
      d = {sink_real, sink_imag};
      m_rdv = rd_en;
      m_rdk = rd_en && (m_cnt > 0);
      if (m_rdk) m_rdd = m_fr[m_head][rd_addr];
      if (sink_valid && m_ready) begin
        if (sink_sop) begin
          if (m_mode != 0) ep = 1;
          if (sink_eop) begin es = 1; m_mode = 0; m_n = 0; end
          else begin m_cur[0] = d; m_n = 1; m_mode = 1; end
        end else if (m_mode == 1) begin
          m_cur[m_n] = d;
          m_n++;
          if (sink_eop) begin
            if (m_n == LEN) begin
              for (int j = 0; j < LEN; j++) m_fr[(m_head + m_cnt) % 2][j] = m_cur[j];
              m_cnt++;
              m_fcnt++;
            end else es = 1;
            m_mode = 0;
          end else if (m_n == LEN) begin
            el = 1; m_mode = 2;
          end
        end else if (m_mode == 2 && sink_eop) begin
          m_mode = 0;
        end
      end
      if (frame_ack && m_cnt > 0) begin m_head = 1 - m_head; m_cnt--; end
      m_es = (m_es && !err_clr) || es;
      m_el = (m_el && !err_clr) || el;
      m_ep = (m_ep && !err_clr) || ep;
      m_ready = (m_mode != 0) || (m_cnt < 2);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("sink_ready", 64'(sink_ready), 64'(m_ready));
      chk("frame_ready", 64'(frame_ready), 64'(m_cnt > 0));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
      chk("err_short", 64'(err_short), 64'(m_es));
      chk("err_long", 64'(err_long), 64'(m_el));
      chk("err_sop", 64'(err_sop), 64'(m_ep));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      if (m_rdv && m_rdk) begin
        chk("rd_real", 64'(rd_real), 64'(m_rdd[63:32]));
        chk("rd_imag", 64'(rd_imag), 64'(m_rdd[31:0]));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!sink_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!sink_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL sink_ready_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic send(input int nb, input bit do_eop, input int sop2, input bit ack_eop);
    for (int k = 0; k < nb; k++) begin
      sink_valid = 1;
      sink_sop   = (k == 0) || (k == sop2);
      sink_eop   = do_eop && (k == nb - 1);
      sink_real  = i2f(seq);
      sink_imag  = i2f(-seq);
      if (ack_eop) frame_ack = sink_eop;
      wait_ready();
      @(posedge clk); #1;
      if (ack_eop) frame_ack = 0;
      seq++;
    end
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
  endtask

  task automatic ack();
    frame_ack = 1; @(posedge clk); #1; frame_ack = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < LEN; a++) begin
      rd_en = 1; rd_addr = AW'(a); @(posedge clk); #1;
    end
    rd_en = 0; @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    reset = 0; #1;
    chk("ready_at_release", 64'(sink_ready), 64'd0);
    chk("cnt_at_release", 64'(frame_cnt), 64'd0);
    chk("fready_at_release", 64'(frame_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_first_clk", 64'(sink_ready), 64'd1);

    // clean frame: real=index, imag=-index
    send(16, 1, -1, 0);
    chk("fready_after_eop", 64'(frame_ready), 64'd1);
    chk("cnt_first", 64'(frame_cnt), 64'd1);
    rd_en = 1; rd_addr = 4'd1; @(posedge clk); #1; rd_en = 0;
    chk("rd_lit_real", 64'(rd_real), 64'(FLOAT_ONE));
    chk("rd_lit_imag", 64'(rd_imag), 64'h0000_0000_BF80_0000);
    chk("rd_lit_valid", 64'(rd_valid), 64'd1);
    read_all();
    ack();
    chk("fready_after_ack", 64'(frame_ready), 64'd0);

    // three back-to-back frames, third stalls until one bank is released
    fork
      begin send(16, 1, -1, 0); send(16, 1, -1, 0); send(16, 1, -1, 0); end
      begin
        repeat (50) @(posedge clk); #1;
        chk("ready_both_full", 64'(sink_ready), 64'd0);
        chk("cnt_two_more", 64'(frame_cnt), 64'd3);
        ack();
      end
    join
    chk("cnt_after_third", 64'(frame_cnt), 64'd4);
    read_all(); ack();
    read_all(); ack();

    // short frame then a good one
    send(10, 1, -1, 0);
    chk("err_short_set", 64'(err_short), 64'd1);
    chk("fready_short", 64'(frame_ready), 64'd0);
    chk("cnt_short", 64'(frame_cnt), 64'd4);
    send(16, 1, -1, 0);
    read_all(); ack();

    // long frame, then sop on beat 5 restarting a frame
    send(20, 1, -1, 0);
    chk("err_long_set", 64'(err_long), 64'd1);
    chk("cnt_long", 64'(frame_cnt), 64'd5);
    send(20, 1, 4, 0);
    chk("err_sop_set", 64'(err_sop), 64'd1);
    chk("cnt_sop_restart", 64'(frame_cnt), 64'd6);
    read_all(); ack();
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    chk("clr_short", 64'(err_short), 64'd0);
    chk("clr_long", 64'(err_long), 64'd0);
    chk("clr_sop", 64'(err_sop), 64'd0);

    // ack on the eop cycle of the second frame
    send(16, 1, -1, 0);
    send(16, 1, -1, 1);
    chk("fready_ack_on_eop", 64'(frame_ready), 64'd1);
    chk("cnt_ack_on_eop", 64'(frame_cnt), 64'd8);
    read_all(); ack();
    chk("fready_drained", 64'(frame_ready), 64'd0);

    // reset mid-frame at beat 7
    send(7, 0, -1, 0);
    #2 reset = 1; #1;
    chk("rst_ready", 64'(sink_ready), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_fready", 64'(frame_ready), 64'd0);
    chk("rst_rdvalid", 64'(rd_valid), 64'd0);
    chk("rst_rdreal", 64'(rd_real), 64'd0);
    @(posedge clk); #1; reset = 0;
    @(posedge clk); #1;
    send(16, 1, -1, 0);
    chk("cnt_after_reset", 64'(frame_cnt), 64'd1);
    chk("fready_after_reset", 64'(frame_ready), 64'd1);
    read_all(); ack();

    repeat (2) @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
